useq_ctrl: RTL and testbench

- Microcode sequencer and decoder for the Robertson signed multiplier control unit.
- Consumes the current micro-PC (upc) from the micro-PC register and decodes the microinstruction at that address.
- Drives the datapath control strobes.
- Returns load_incr/upc_next to the micro-PC register, closing the sequencing loop.
- Owns the iteration counter and the start/done handshake with the host.

---
 rtl/useq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_useq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/useq_ctrl.sv
`timescale 1ns/1ps
// useq_ctrl: microcode sequencer/decoder, iteration counter and start/done handshake
// for a Robertson signed multiplier. Optional macro USEQ_TRAP_EN traps illegal micro-PCs.
module useq_ctrl #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] upc,
    input  logic       start,
    input  logic       q0,
    output logic       load_incr,
    output logic [4:0] upc_next,
    output logic       ld_m,
    output logic       ld_q,
    output logic       clr_a,
    output logic       add,
    output logic       sub,
    output logic       shift,
    output logic       busy,
    output logic       done
`ifdef USEQ_TRAP_EN
    ,
    output logic       err
`endif
);

    localparam int unsigned UPC_W = 5;

    localparam logic [UPC_W-1:0] U_IDLE   = UPC_W'(0);
    localparam logic [UPC_W-1:0] U_INIT   = UPC_W'(1);
    localparam logic [UPC_W-1:0] U_TEST   = UPC_W'(2);
    localparam logic [UPC_W-1:0] U_ADD    = UPC_W'(3);
    localparam logic [UPC_W-1:0] U_SHIFT  = UPC_W'(4);
    localparam logic [UPC_W-1:0] U_LOOP   = UPC_W'(5);
    localparam logic [UPC_W-1:0] U_TLAST  = UPC_W'(6);
    localparam logic [UPC_W-1:0] U_SUB    = UPC_W'(7);
    localparam logic [UPC_W-1:0] U_LSHIFT = UPC_W'(8);
    localparam logic [UPC_W-1:0] U_DONE   = UPC_W'(9);
`ifdef USEQ_TRAP_EN
    localparam logic [UPC_W-1:0] U_BAD    = UPC_W'(31);
`else
    localparam logic [UPC_W-1:0] U_BAD    = UPC_W'(0);
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             illegal;
    logic             start_acc;
`ifdef USEQ_TRAP_EN
    logic             err_q, err_d;
`endif

    assign illegal   = (upc > U_DONE);
    assign start_acc = (upc == U_IDLE) && start;

    // Microinstruction decode: strobes and branch control from the current address.
    always_comb begin
        load_incr = 1'b0;
        upc_next  = '0;
        ld_m      = 1'b0;
        ld_q      = 1'b0;
        clr_a     = 1'b0;
        add       = 1'b0;
        sub       = 1'b0;
        shift     = 1'b0;
        case (upc)
            U_IDLE: begin
                if (!start) begin
                    load_incr = 1'b1;
                    upc_next  = U_IDLE;
                end
            end
            U_INIT: begin
                ld_m  = 1'b1;
                ld_q  = 1'b1;
                clr_a = 1'b1;
            end
            U_TEST: begin
                if (!q0) begin
                    load_incr = 1'b1;
                    upc_next  = U_SHIFT;
                end
            end
            U_ADD:   add   = 1'b1;
            U_SHIFT: shift = 1'b1;
            U_LOOP: begin
                // cnt was already decremented at SHIFT, so zero means the last add/shift step is done
                if (cnt_q != '0) begin
                    load_incr = 1'b1;
                    upc_next  = U_TEST;
                end
            end
            U_TLAST: begin
                if (!q0) begin
                    load_incr = 1'b1;
                    upc_next  = U_LSHIFT;
                end
            end
            U_SUB:    sub   = 1'b1;
            U_LSHIFT: shift = 1'b1;
            U_DONE: begin
                load_incr = 1'b1;
                upc_next  = U_IDLE;
            end
            default: begin
                load_incr = 1'b1;
                upc_next  = U_BAD;
            end
        endcase
    end

    // Next-state for the iteration counter and handshake flags.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
`ifdef USEQ_TRAP_EN
        err_d  = err_q | illegal;
`endif
        if (start_acc) begin
            busy_d = 1'b1;
            done_d = 1'b0;
        end
        if (upc == U_INIT) begin
            cnt_d = CNT_W'(N - 1);
        end
        if ((upc == U_SHIFT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (upc == U_DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
`ifndef USEQ_TRAP_EN
        if (illegal) begin
            busy_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef USEQ_TRAP_EN
            err_q  <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
`ifdef USEQ_TRAP_EN
            err_q  <= err_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
`ifdef USEQ_TRAP_EN
    assign err  = err_q;
`endif

endmodule

// File: tb/tb_useq_ctrl.sv
`timescale 1ns/1ps
// tb_useq_ctrl: closes the micro-PC loop and a Robertson datapath around useq_ctrl,
// checks products, strobe counts and latency against arithmetic expectations.
module tb_useq_ctrl;

    localparam int unsigned N = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] upc;
    logic       start = 1'b0;
    logic       q0;
    logic       load_incr;
    logic [4:0] upc_next;
    logic       ld_m, ld_q, clr_a, add, sub, shift;
    logic       busy, done;
`ifdef USEQ_TRAP_EN
    logic       err;
`endif

    logic [4:0]        upc_q = '0;
    logic              force_en = 1'b0;
    logic [4:0]        force_val = '0;
    logic signed [7:0] m_in = '0;
    logic signed [7:0] q_in = '0;
    int                acc = 0;
    int                mval = 0;
    logic [7:0]        qreg = '0;

    int chk_cnt = 0;
    int pass_cnt = 0;

    useq_ctrl #(.N(N), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .upc       (upc),
        .start     (start),
        .q0        (q0),
        .load_incr (load_incr),
        .upc_next  (upc_next),
        .ld_m      (ld_m),
        .ld_q      (ld_q),
        .clr_a     (clr_a),
        .add       (add),
        .sub       (sub),
        .shift     (shift),
        .busy      (busy),
        .done      (done)
`ifdef USEQ_TRAP_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    // Micro-PC register
    always @(posedge clk) begin
        if (reset)          upc_q <= '0;
        else if (load_incr) upc_q <= upc_next;
        else                upc_q <= upc_q + 5'd1;
    end
    assign upc = force_en ? force_val : upc_q;

    // Datapath with a full-precision accumulator so the sum never overflows
    always @(posedge clk) begin
        if (ld_m) mval <= int'(m_in);
        if (clr_a)      acc <= 0;
        else if (add)   acc <= acc + mval;
        else if (sub)   acc <= acc - mval;
        else if (shift) acc <= acc >>> 1;
        if (ld_q)       qreg <= q_in;
        else if (shift) qreg <= {acc[0], qreg[7:1]};
    end
    assign q0 = qreg[0];

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        chk_cnt++;
        if (dut.cnt_q !== 3'd0) $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q); else pass_cnt++;
`ifdef USEQ_TRAP_EN
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_idle;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_cnt++;
            if (upc_q !== 5'd0 || load_incr !== 1'b1 || upc_next !== 5'd0 || busy !== 1'b0 || done !== 1'b0 ||
                {ld_m, ld_q, clr_a, add, sub, shift} !== 6'b0)
                $display("FAIL idle_hold[%0d]: upc=%0d li=%b nx=%0d busy=%b done=%b want 0 1 0 0 0",
                         i, upc_q, load_incr, upc_next, busy, done);
            else pass_cnt++;
        end
    endtask

    task automatic test_multiply(input logic signed [7:0] mi, input logic signed [7:0] qi);
        int z, w, exp_lat, exp_prod, prod, n, adds, subs, loops, taken;
        bit got;
        z = 0;
        for (int i = 0; i < int'(N) - 1; i++) if (qi[i] == 1'b0) z++;
        w        = int'(qi[N-1]);
        exp_lat  = 1 + 4 * (int'(N) - 1) - z + 4 + w;
        exp_prod = int'(mi) * int'(qi);
        @(negedge clk);
        chk_cnt++;
        if (upc_q !== 5'd0) $display("FAIL mul_idle_before: upc=%0d want 0", upc_q); else pass_cnt++;
        m_in = mi;
        q_in = qi;
        start = 1'b1;
        n = 0; got = 1'b0; adds = 0; subs = 0; loops = 0; taken = 0;
        while (!got && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                start = 1'b0;
                chk_cnt++;
                if (busy !== 1'b1 || done !== 1'b0)
                    $display("FAIL mul_start_edge: busy=%b done=%b want 1 0", busy, done);
                else pass_cnt++;
            end
            if (done === 1'b1) got = 1'b1;
            else begin
                adds += int'(add);
                subs += int'(sub);
                if (upc_q == 5'd5) begin
                    loops++;
                    if (load_incr) taken++;
                end
            end
        end
        prod = acc * 256 + int'(qreg);
        chk_cnt++;
        if (n != exp_lat) $display("FAIL mul_latency M=%0d Q=%0d: got %0d want %0d", mi, qi, n, exp_lat); else pass_cnt++;
        chk_cnt++;
        if (prod != exp_prod) $display("FAIL mul_product M=%0d Q=%0d: got %0d want %0d", mi, qi, prod, exp_prod); else pass_cnt++;
        chk_cnt++;
        if (adds != int'(N) - 1 - z) $display("FAIL mul_adds Q=%0d: got %0d want %0d", qi, adds, int'(N) - 1 - z); else pass_cnt++;
        chk_cnt++;
        if (subs != w) $display("FAIL mul_subs Q=%0d: got %0d want %0d", qi, subs, w); else pass_cnt++;
        chk_cnt++;
        if (loops != int'(N) - 1 || taken != int'(N) - 2)
            $display("FAIL mul_loop: visits %0d taken %0d want %0d %0d", loops, taken, int'(N) - 1, int'(N) - 2);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL mul_busy_at_done: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        test_multiply(8'sd127, -8'sd128);
        test_multiply(-8'sd128, -8'sd128);
        test_multiply(-8'sd1, 8'sd1);
    endtask

    task automatic test_random;
        logic signed [7:0] mi, qi;
        for (int i = 0; i < 8; i++) begin
            mi = 8'($urandom);
            qi = 8'($urandom);
            test_multiply(mi, qi);
        end
    endtask

    task automatic test_reset_mid;
        int k;
        @(negedge clk);
        m_in = 8'sd11;
        q_in = 8'sd13;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (upc_q != 5'd4 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk_cnt++;
        if (upc_q !== 5'd4) $display("FAIL rst_mid_reach: upc=%0d want 4", upc_q); else pass_cnt++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_flags: busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
        chk_cnt++;
        if (dut.cnt_q !== 3'd0) $display("FAIL rst_mid_cnt: got %0d want 0", dut.cnt_q); else pass_cnt++;
        chk_cnt++;
        if (upc_q !== 5'd0 || load_incr !== 1'b1 || upc_next !== 5'd0)
            $display("FAIL rst_mid_idle: upc=%0d li=%b nx=%0d want 0 1 0", upc_q, load_incr, upc_next);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_cnt++;
            if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_no_done[%0d]: busy=%b done=%b want 0 0", i, busy, done); else pass_cnt++;
        end
        test_multiply(8'sd11, 8'sd13);
    endtask

    task automatic test_illegal;
        @(negedge clk);
        m_in = 8'sd3;
        q_in = 8'sd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL ill_busy_before: got %b want 1", busy); else pass_cnt++;
        force_val = 5'd17;
        force_en = 1'b1;
        #1;
        chk_cnt++;
`ifdef USEQ_TRAP_EN
        if (load_incr !== 1'b1 || upc_next !== 5'd31) $display("FAIL ill_decode: li=%b nx=%0d want 1 31", load_incr, upc_next); else pass_cnt++;
`else
        if (load_incr !== 1'b1 || upc_next !== 5'd0) $display("FAIL ill_decode: li=%b nx=%0d want 1 0", load_incr, upc_next); else pass_cnt++;
`endif
        @(posedge clk);
        #1;
        force_en = 1'b0;
        #1;
`ifdef USEQ_TRAP_EN
        chk_cnt++;
        if (err !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || upc_q !== 5'd31)
            $display("FAIL ill_trap: err=%b busy=%b done=%b upc=%0d want 1 1 0 31", err, busy, done, upc_q);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_cnt++;
            if (err !== 1'b1 || upc_q !== 5'd31 || busy !== 1'b1)
                $display("FAIL ill_trap_hold[%0d]: err=%b upc=%0d busy=%b want 1 31 1", i, err, upc_q, busy);
            else pass_cnt++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (err !== 1'b0 || busy !== 1'b0) $display("FAIL ill_reset: err=%b busy=%b want 0 0", err, busy); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
`else
        chk_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || upc_q !== 5'd0)
            $display("FAIL ill_jump0: busy=%b done=%b upc=%0d want 0 0 0", busy, done, upc_q);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_cnt++;
            if (busy !== 1'b0 || upc_q !== 5'd0) $display("FAIL ill_idle[%0d]: busy=%b upc=%0d want 0 0", i, busy, upc_q); else pass_cnt++;
        end
`endif
    endtask

    initial begin
        test_reset;
        test_idle;
        test_multiply(8'sd5, 8'sd3);
        test_multiply(-8'sd7, -8'sd2);
        test_multiply(8'sd9, 8'sd0);
        test_back_to_back;
        test_random;
        test_reset_mid;
        test_illegal;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
